// File: rtl/rca_nibble_sequencer.sv
// rca_nibble_sequencer: multi-cycle operand sequencer and result collector
// wrapped around an external 4-bit ripple carry adder. A W-bit operand pair
// is accepted over valid/ready, fed to the adder one nibble per cycle (LSB
// first) with the adder carry chained between nibbles, and the assembled
// sum, carry-out and two's-complement overflow are offered over valid/ready.
module rca_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   op_cin,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_s,
  input  logic                   add_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   overflow
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST_NIBBLE = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  a_shift;
  logic [W-1:0]  b_shift;
  logic          msb_a;
  logic          msb_b;

  // Operand nibbles still to be fed sit in a_shift/b_shift and move down
  // four bits per cycle; add_a/add_b/add_cin are registered so the adder
  // sees a clean nibble for a whole cycle and add_cin doubles as the carry
  // chain register between nibbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      a_shift   <= '0;
      b_shift   <= '0;
      msb_a     <= 1'b0;
      msb_b     <= 1'b0;
      add_a     <= 4'd0;
      add_b     <= 4'd0;
      add_cin   <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            add_a    <= op_a[3:0];
            add_b    <= op_b[3:0];
            add_cin  <= op_cin;
            a_shift  <= op_a >> 4;
            b_shift  <= op_b >> 4;
            msb_a    <= op_a[W-1];
            msb_b    <= op_b[W-1];
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum[4*cnt +: 4] <= add_s;
          if (cnt == LAST_NIBBLE) begin
            cout      <= add_cout;
            overflow  <= (msb_a == msb_b) && (add_s[3] != msb_a);
            add_a     <= 4'd0;
            add_b     <= 4'd0;
            add_cin   <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            add_a   <= a_shift[3:0];
            add_b   <= b_shift[3:0];
            add_cin <= add_cout;
            a_shift <= a_shift >> 4;
            b_shift <= b_shift >> 4;
            cnt     <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca_nibble_sequencer.sv
// Self-checking bench for rca_nibble_sequencer (NIBBLES=4). A behavioural
// 4-bit adder closes the add_* loop; expected results come from a W-bit
// reference sum pushed to a scoreboard when operands are accepted.
module tb_rca_nibble_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_cin;
  logic [3:0]  add_a;
  logic [3:0]  add_b;
  logic        add_cin;
  logic [3:0]  add_s;
  logic        add_cout;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        overflow;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   fails;
  logic [3:0] cin_trace;

  rca_nibble_sequencer #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_cin    (op_cin),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  // Behavioural stand-in for the external ripple carry adder
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};

  // Free-running clock, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t reference(input logic [15:0] a, input logic [15:0] b, input logic c);
    exp_t        e;
    logic [16:0] r;
    r     = {1'b0, a} + {1'b0, b} + {16'd0, c};
    e.sum = r[15:0];
    e.cout = r[16];
    e.ovf = (a[15] == b[15]) && (r[15] != a[15]);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer an operand pair, then walk the four RUN cycles recording add_cin
  task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] b, input logic c);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    op_cin   = c;
    tick();
    in_valid = 1'b0;
    op_a     = 16'($urandom);
    op_b     = 16'($urandom);
    op_cin   = 1'($urandom);
    sb.push_back(reference(a, b, c));
    check("in_ready_run", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cin_trace[i] = add_cin;
      if (i < 3) check("out_valid_early", {31'd0, out_valid}, 32'd0);
      tick();
    end
  endtask

  // Compare the presented result against the scoreboard head, then accept it
  task automatic check_output();
    exp_t e;
    int   n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("latency", n, 0);
    check("out_valid", {31'd0, out_valid}, 32'd1);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, {31'd0, out_valid} ^ 32'd1);
    end else begin
      e = sb.pop_front();
      check("sum", {16'd0, sum}, {16'd0, e.sum});
      check("cout", {31'd0, cout}, {31'd0, e.cout});
      check("overflow", {31'd0, overflow}, {31'd0, e.ovf});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_drop", {31'd0, out_valid}, 32'd0);
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
  endtask

  // Directed sequence of test steps
  initial begin
    logic [15:0] held;
    vectors   = 0;
    fails     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = 16'd0;
    op_b      = 16'd0;
    op_cin    = 1'b0;
    cin_trace = 4'd0;
    #12;
    check("rst_sum", {16'd0, sum}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_add", {23'd0, add_a, add_b, add_cin}, 32'd0);
    check("rst_flags", {30'd0, cout, overflow}, 32'd0);
    rst_n = 1'b1;
    tick();

    apply_stimulus(16'h0000, 16'h0000, 1'b0);
    check_output();

    apply_stimulus(16'h00FF, 16'h0001, 1'b0);
    check("cin_trace", {28'd0, cin_trace}, 32'b0110);
    check_output();

    apply_stimulus(16'hFFFF, 16'h0000, 1'b1);
    check("cin_trace_ripple", {28'd0, cin_trace}, 32'b1111);
    check_output();

    apply_stimulus(16'h7FFF, 16'h0001, 1'b0);
    check_output();
    apply_stimulus(16'h8000, 16'h8000, 1'b0);
    check_output();
    apply_stimulus(16'hA5C3, 16'h3C5A, 1'b1);
    check_output();

    // Backpressure: result must hold while a stray operand pulse is ignored
    apply_stimulus(16'h1357, 16'h2468, 1'b1);
    held = sum;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        in_valid = 1'b1;
        op_a     = 16'hDEAD;
        op_b     = 16'hBEEF;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      check("bp_sum_stable", {16'd0, sum}, {16'd0, held});
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    check_output();
    apply_stimulus(16'h0F0F, 16'h00F1, 1'b0);
    check_output();

    // Reset in the middle of RUN, two nibbles in
    in_valid = 1'b1;
    op_a     = 16'hFFFF;
    op_b     = 16'hFFFF;
    op_cin   = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrun_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrun_sum", {16'd0, sum}, 32'd0);
    check("midrun_add", {23'd0, add_a, add_b, add_cin}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    apply_stimulus(16'h1234, 16'h1111, 1'b0);
    check_output();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
